// File: rtl/chaser_ctrl.sv
// Operator-control front end for the LED chaser: debounced run/direction/speed
// buttons and a rate-selectable one-cycle step strobe.
module chaser_ctrl #(
    parameter int TICK_BASE = 12_000_000,
    parameter int DB_CYCLES = 240_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] key_n,
    output logic       tick,
    output logic       run,
    output logic       dir,
    output logic [1:0] speed
);
    localparam int CW = $clog2(TICK_BASE);
    localparam int DW = $clog2(DB_CYCLES);
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);

    logic [2:0]         sync1_q, sync2_q;
    logic [2:0]         db_q, db_d;
    logic [2:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic [2:0]         db_prev_q;
    logic [2:0]         press_q, press_d;
    logic [CW-1:0]      cnt_q, cnt_d, cnt_last;
    logic               tick_q, tick_d;
    logic               run_q, run_d;
    logic               dir_q, dir_d;
    logic [1:0]         speed_q, speed_d;

    // A key's debounced state flips only after DB_CYCLES back-to-back samples disagree with it.
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        for (int k = 0; k < 3; k++) begin
            if (sync2_q[k] != db_q[k]) begin
                if (db_cnt_q[k] == DB_LAST) begin
                    db_d[k] = sync2_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + DW'(1);
                end
            end
        end
    end

    assign press_d  = db_prev_q & ~db_q;
    assign cnt_last = CW'((TICK_BASE >> speed_q) - 1);

    // A speed change restarts the period; tick decision uses run before any toggle.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (press_q[2]) begin
            cnt_d = '0;
        end else if (run_q) begin
            if (cnt_q == cnt_last) begin
                tick_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        run_d   = run_q ^ press_q[0];
        dir_d   = dir_q ^ press_q[1];
        speed_d = speed_q + {1'b0, press_q[2]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            db_q      <= '1;
            db_prev_q <= '1;
            db_cnt_q  <= '0;
            press_q   <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            run_q     <= 1'b1;
            dir_q     <= 1'b0;
            speed_q   <= 2'd0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_prev_q <= db_q;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            run_q     <= run_d;
            dir_q     <= dir_d;
            speed_q   <= speed_d;
        end
    end

    assign tick  = tick_q;
    assign run   = run_q;
    assign dir   = dir_q;
    assign speed = speed_q;

endmodule

// File: tb/tb_chaser_ctrl.sv
// Bench for chaser_ctrl: scenario tasks plus randomized key activity, all
// checked against a window-based behavioural model of the button/tick rules.
module tb_chaser_ctrl;
    localparam int TB_BASE = 16;
    localparam int TB_DB   = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [2:0] key_n = 3'b111;
    logic       tick, run, dir;
    logic [1:0] speed;

    int n_cmp = 0;
    int n_err = 0;

    chaser_ctrl #(.TICK_BASE(TB_BASE), .DB_CYCLES(TB_DB)) dut (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_n),
        .tick  (tick),
        .run   (run),
        .dir   (dir),
        .speed (speed)
    );

    always #5 clk = ~clk;

    // Reference model: raw samples history, press = DB_CYCLES consecutive samples
    // (seen two edges late) opposing the held state; actions land two edges later.
    logic [2:0] m_hist[$];
    logic [2:0] m_db;
    int         act_due[$];
    logic [2:0] act_mask[$];
    int         m_elapsed, m_edge;
    logic       m_tick, m_run, m_dir;
    logic [1:0] m_speed;

    function automatic void model_reset();
        m_hist = {};
        for (int i = 0; i < TB_DB + 2; i++) m_hist.push_back(3'b111);
        act_due   = {};
        act_mask  = {};
        m_db      = 3'b111;
        m_elapsed = 0;
        m_edge    = 0;
        m_tick    = 1'b0;
        m_run     = 1'b1;
        m_dir     = 1'b0;
        m_speed   = 2'd0;
    endfunction

    function automatic void model_step(input logic [2:0] raw);
        logic [2:0] fresh, act;
        bit         steady;
        int         period;
        m_edge++;
        m_hist.push_front(raw);
        void'(m_hist.pop_back());
        fresh = 3'b000;
        for (int k = 0; k < 3; k++) begin
            steady = 1'b1;
            for (int j = 0; j < TB_DB; j++) if (m_hist[2+j][k] == m_db[k]) steady = 1'b0;
            if (steady) begin
                fresh[k] = m_db[k];
                m_db[k]  = ~m_db[k];
            end
        end
        act = 3'b000;
        if (act_due.size() > 0 && act_due[0] == m_edge) begin
            act = act_mask[0];
            void'(act_due.pop_front());
            void'(act_mask.pop_front());
        end
        if (fresh != 3'b000) begin
            act_due.push_back(m_edge + 2);
            act_mask.push_back(fresh);
        end
        period = TB_BASE >> m_speed;
        m_tick = 1'b0;
        if (act[2]) m_elapsed = 0;
        else if (m_run) begin
            if (m_elapsed == period - 1) begin
                m_tick    = 1'b1;
                m_elapsed = 0;
            end else m_elapsed++;
        end
        if (act[0]) m_run = ~m_run;
        if (act[1]) m_dir = ~m_dir;
        if (act[2]) m_speed = m_speed + 2'd1;
    endfunction

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step(key_n);
        end
    end

    task automatic test_reset();
        rst   = 1'b0;
        key_n = 3'b111;
        repeat (3) @(negedge clk);
        n_cmp++; if (tick !== 1'b0)   begin n_err++; $display("FAIL reset_tick: got %b want 0", tick); end
        n_cmp++; if (run !== 1'b1)    begin n_err++; $display("FAIL reset_run: got %b want 1", run); end
        n_cmp++; if (dir !== 1'b0)    begin n_err++; $display("FAIL reset_dir: got %b want 0", dir); end
        n_cmp++; if (speed !== 2'd0)  begin n_err++; $display("FAIL reset_speed: got %0d want 0", speed); end
        rst = 1'b1;
    endtask

    task automatic test_free_run();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== ((m_edge % TB_BASE) == 0)) begin
                n_err++; $display("FAIL free_tick: edge %0d got %b", m_edge, tick);
            end
        end
        n_cmp++; if (run !== 1'b1)   begin n_err++; $display("FAIL free_run: got %b want 1", run); end
        n_cmp++; if (dir !== 1'b0)   begin n_err++; $display("FAIL free_dir: got %b want 0", dir); end
        n_cmp++; if (speed !== 2'd0) begin n_err++; $display("FAIL free_speed: got %0d want 0", speed); end
    endtask

    task automatic test_run_pause();
        int s, h, r, first;
        key_n[0] = 1'b0;
        repeat (3) @(negedge clk);
        key_n[0] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_cmp++; if (run !== 1'b1)    begin n_err++; $display("FAIL glitch_run: got %b want 1", run); end
            n_cmp++; if (tick !== m_tick) begin n_err++; $display("FAIL glitch_tick: got %b want %b", tick, m_tick); end
        end
        s = m_edge + 1;
        key_n[0] = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 10) key_n[0] = 1'b1;
            n_cmp++;
            if (run !== (m_edge < s + 7)) begin
                n_err++; $display("FAIL pause_latency: edge %0d got %b want %b", m_edge - s, run, (m_edge < s + 7));
            end
            n_cmp++; if (tick !== m_tick) begin n_err++; $display("FAIL pause_tick: got %b want %b", tick, m_tick); end
        end
        h = m_elapsed;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++; if (tick !== 1'b0) begin n_err++; $display("FAIL paused_tick: got %b want 0", tick); end
            n_cmp++; if (run !== 1'b0)  begin n_err++; $display("FAIL paused_run: got %b want 0", run); end
        end
        s = m_edge + 1;
        r = s + 7;
        first = -1;
        key_n[0] = 1'b0;
        for (int c = 1; c <= 40 && first < 0; c++) begin
            @(negedge clk);
            if (c == 10) key_n[0] = 1'b1;
            n_cmp++; if (tick !== m_tick) begin n_err++; $display("FAIL resume_tick: got %b want %b", tick, m_tick); end
            n_cmp++; if (run !== m_run)   begin n_err++; $display("FAIL resume_run: got %b want %b", run, m_run); end
            if (tick === 1'b1) first = m_edge;
        end
        key_n[0] = 1'b1;
        n_cmp++;
        if (first != r + TB_BASE - h) begin
            n_err++; $display("FAIL resume_first: got edge %0d want %0d", first, r + TB_BASE - h);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_speed();
        for (int i = 1; i <= 4; i++) begin
            logic [1:0] want;
            int chg, first, cyc, s;
            want  = 2'(i);
            chg   = -1;
            first = -1;
            cyc   = 0;
            s     = m_edge + 1;
            key_n[2] = 1'b0;
            while ((cyc < 20 || first < 0) && cyc < 60) begin
                @(negedge clk);
                cyc++;
                if (cyc == 10) key_n[2] = 1'b1;
                n_cmp++; if (tick !== m_tick)   begin n_err++; $display("FAIL speed_tick: got %b want %b", tick, m_tick); end
                n_cmp++; if (speed !== m_speed) begin n_err++; $display("FAIL speed_val: got %0d want %0d", speed, m_speed); end
                if (chg < 0) begin
                    if (speed === want) chg = m_edge;
                end else if (first < 0 && tick === 1'b1) first = m_edge;
            end
            key_n[2] = 1'b1;
            n_cmp++; if (chg != s + 7) begin n_err++; $display("FAIL speed_latency: got %0d want %0d", chg - s, 7); end
            n_cmp++;
            if (first - chg != (TB_BASE >> (i % 4))) begin
                n_err++; $display("FAIL speed_period: got %0d want %0d", first - chg, TB_BASE >> (i % 4));
            end
        end
    endtask

    task automatic test_bounce_dir();
        int   changes;
        logic prev_dir;
        changes  = 0;
        prev_dir = dir;
        for (int c = 0; c < 130; c++) begin
            key_n[1] = (c == 1 || c == 102 || c >= 104);
            @(negedge clk);
            n_cmp++; if (dir !== m_dir) begin n_err++; $display("FAIL bounce_dir: got %b want %b", dir, m_dir); end
            if (dir !== prev_dir) changes++;
            prev_dir = dir;
        end
        n_cmp++; if (changes != 1) begin n_err++; $display("FAIL bounce_toggles: got %0d want 1", changes); end
    endtask

    task automatic test_simultaneous();
        int   s, run_at, dir_at;
        logic prev_run, prev_dir;
        s        = m_edge + 1;
        run_at   = -1;
        dir_at   = -1;
        prev_run = run;
        prev_dir = dir;
        key_n[1:0] = 2'b00;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 10) key_n[1:0] = 2'b11;
            if (run !== prev_run && run_at < 0) run_at = m_edge;
            if (dir !== prev_dir && dir_at < 0) dir_at = m_edge;
            prev_run = run;
            prev_dir = dir;
        end
        n_cmp++; if (run_at != s + 7) begin n_err++; $display("FAIL simul_run: got %0d want %0d", run_at - s, 7); end
        n_cmp++; if (dir_at != s + 7) begin n_err++; $display("FAIL simul_dir: got %0d want %0d", dir_at - s, 7); end
        n_cmp++; if (run !== m_run)   begin n_err++; $display("FAIL simul_run_val: got %b want %b", run, m_run); end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 40; seg++) begin
            key_n = 3'($urandom_range(0, 7));
            repeat ($urandom_range(1, 12)) begin
                @(negedge clk);
                n_cmp++; if (tick !== m_tick)   begin n_err++; $display("FAIL rand_tick: got %b want %b", tick, m_tick); end
                n_cmp++; if (run !== m_run)     begin n_err++; $display("FAIL rand_run: got %b want %b", run, m_run); end
                n_cmp++; if (dir !== m_dir)     begin n_err++; $display("FAIL rand_dir: got %b want %b", dir, m_dir); end
                n_cmp++; if (speed !== m_speed) begin n_err++; $display("FAIL rand_speed: got %0d want %0d", speed, m_speed); end
            end
        end
        key_n = 3'b111;
        repeat (12) begin
            @(negedge clk);
            n_cmp++; if (tick !== m_tick) begin n_err++; $display("FAIL rand_tail_tick: got %b want %b", tick, m_tick); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4 && m_speed != 2'd2; i++) begin
            key_n[2] = 1'b0;
            repeat (10) @(negedge clk);
            key_n[2] = 1'b1;
            repeat (10) @(negedge clk);
        end
        if (m_dir == 1'b0) begin
            key_n[1] = 1'b0;
            repeat (10) @(negedge clk);
            key_n[1] = 1'b1;
            repeat (10) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        n_cmp++; if (speed !== 2'd2) begin n_err++; $display("FAIL pre_reset_speed: got %0d want 2", speed); end
        n_cmp++; if (dir !== 1'b1)   begin n_err++; $display("FAIL pre_reset_dir: got %b want 1", dir); end
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (tick !== 1'b0)  begin n_err++; $display("FAIL midrst_tick: got %b want 0", tick); end
        n_cmp++; if (run !== 1'b1)   begin n_err++; $display("FAIL midrst_run: got %b want 1", run); end
        n_cmp++; if (dir !== 1'b0)   begin n_err++; $display("FAIL midrst_dir: got %b want 0", dir); end
        n_cmp++; if (speed !== 2'd0) begin n_err++; $display("FAIL midrst_speed: got %0d want 0", speed); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_cmp++;
            if (tick !== ((m_edge % TB_BASE) == 0)) begin
                n_err++; $display("FAIL midrst_first_tick: edge %0d got %b", m_edge, tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_run_pause();
        test_speed();
        test_bounce_dir();
        test_simultaneous();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
